uart_loader: RTL and testbench

- Downstream consumer of the UART RX byte stream. Parses a framed image-download command and assembles little-endian words.
- Writes each assembled word into program memory through the same write/operand/operand_addr style port that the core uses.
- Holds the core in reset during a download and returns an ACK or NAK byte through the TX ready/valid handshake.
- Sits between the RX/TX pair and the core/memory pair in the UART top level.

---
 rtl/uart_loader.sv | 197 +++++++++++++++++++
 tb/tb_uart_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: consumes the UART RX byte stream and parses a framed image download.
// Assembles little-endian words and writes them into program memory.
// Holds the core in reset while loading, then answers with ACK or NAK over TX.
module uart_loader #(
  parameter int          WORD_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 5,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int          TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  mem_write,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  err
);

  localparam int BPW   = WORD_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BIW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  // One extra bit so the word total can hold DEPTH itself (COUNT byte of 0).
  localparam int WIW   = ADDR_WIDTH + 1;

  localparam logic [WIW-1:0] DEPTH_W   = WIW'(DEPTH);
  localparam logic [TW-1:0]  TIMEOUT_W = TW'(TIMEOUT_CYCLES);
  localparam logic [BIW-1:0] LAST_LANE = BIW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CSUM,
    S_REPLY
  } state_t;

  state_t                state;
  logic [BIW-1:0]        byte_idx;
  logic [WIW-1:0]        word_idx;
  logic [WIW-1:0]        word_total;
  logic [7:0]            checksum;
  logic [TW-1:0]         timer;
  logic [WORD_WIDTH-1:0] asm_word;
  logic                  reply_ack;

  logic [WORD_WIDTH-1:0] asm_next;
  logic                  count_too_big;
  logic                  timer_expired;
  logic                  last_byte;
  logic                  last_word;

  // Merge the incoming byte into its lane so a completed word can be written in one step.
  always_comb begin
    asm_next = asm_word;
    for (int i = 0; i < BPW; i++) begin
      if (BIW'(i) == byte_idx) begin
        asm_next[i*8 +: 8] = rx_data;
      end
    end
  end

  assign count_too_big = (32'(rx_data) > DEPTH);
  assign timer_expired = (timer == TIMEOUT_W);
  assign last_byte     = (byte_idx == LAST_LANE);
  assign last_word     = (word_idx == (word_total - WIW'(1)));

  // The TX side must never see a request while it is not ready, so valid is gated by ready.
  assign tx_valid = (state == S_REPLY) && tx_ready;
  assign busy     = (state != S_IDLE);

  // Frame parser: header, word count, data bytes, checksum, then the reply handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_data    <= 8'd0;
      mem_write  <= 1'b0;
      mem_data   <= '0;
      mem_addr   <= '0;
      core_reset <= 1'b0;
      err        <= 1'b0;
      byte_idx   <= '0;
      word_idx   <= '0;
      word_total <= '0;
      checksum   <= 8'd0;
      timer      <= '0;
      asm_word   <= '0;
      reply_ack  <= 1'b0;
    end else begin
      mem_write <= 1'b0;

      if (rx_valid || state == S_IDLE || state == S_REPLY) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == HEADER) begin
            core_reset <= 1'b1;
            err        <= 1'b0;
            checksum   <= 8'd0;
            word_idx   <= '0;
            byte_idx   <= '0;
            state      <= S_COUNT;
          end
        end

        S_COUNT: begin
          if (rx_valid) begin
            if (count_too_big) begin
              err       <= 1'b1;
              tx_data   <= NAK_BYTE;
              reply_ack <= 1'b0;
              state     <= S_REPLY;
            end else begin
              word_total <= (rx_data == 8'd0) ? DEPTH_W : WIW'(rx_data);
              state      <= S_DATA;
            end
          end else if (timer_expired) begin
            err       <= 1'b1;
            tx_data   <= NAK_BYTE;
            reply_ack <= 1'b0;
            state     <= S_REPLY;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            asm_word <= asm_next;
            checksum <= checksum + rx_data;
            if (last_byte) begin
              mem_write <= 1'b1;
              mem_data  <= asm_next;
              mem_addr  <= word_idx[ADDR_WIDTH-1:0];
              word_idx  <= word_idx + WIW'(1);
              byte_idx  <= '0;
              if (last_word) begin
                state <= S_CSUM;
              end
            end else begin
              byte_idx <= byte_idx + BIW'(1);
            end
          end else if (timer_expired) begin
            err       <= 1'b1;
            tx_data   <= NAK_BYTE;
            reply_ack <= 1'b0;
            state     <= S_REPLY;
          end
        end

        S_CSUM: begin
          if (rx_valid) begin
            if (rx_data == checksum) begin
              tx_data   <= ACK_BYTE;
              reply_ack <= 1'b1;
            end else begin
              err       <= 1'b1;
              tx_data   <= NAK_BYTE;
              reply_ack <= 1'b0;
            end
            state <= S_REPLY;
          end else if (timer_expired) begin
            err       <= 1'b1;
            tx_data   <= NAK_BYTE;
            reply_ack <= 1'b0;
            state     <= S_REPLY;
          end
        end

        S_REPLY: begin
          // A failed download keeps the core parked so a corrupt image never runs.
          if (tx_ready) begin
            state <= S_IDLE;
            if (reply_ack) begin
              core_reset <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed scoreboard bench for uart_loader.
// Expected memory writes and reply bytes are queued as frames are sent
// and are popped by monitors when the DUT produces them.
module tb_uart_loader;

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_write;
  logic [31:0] mem_data;
  logic [4:0]  mem_addr;
  logic        core_reset;
  logic        busy;
  logic        err;

  int n_assert  = 0;
  int n_fail    = 0;
  int n_replies = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] payload[$];
  logic [7:0] payload_sum;

  uart_loader #(
    .WORD_WIDTH(32),
    .ADDR_WIDTH(5),
    .HEADER(HEADER),
    .ACK_BYTE(ACK_BYTE),
    .NAK_BYTE(NAK_BYTE),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .mem_write(mem_write),
    .mem_data(mem_data),
    .mem_addr(mem_addr),
    .core_reset(core_reset),
    .busy(busy),
    .err(err)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Scoreboard monitors: every write and every reply transfer must match the next queued entry.
  always @(negedge clk) begin
    if (mem_write) begin
      if (wq.size() == 0) begin
        checkOutput("extra_write", {31'd0, mem_write}, 32'd0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        checkOutput("wr_addr", {27'd0, mem_addr}, {27'd0, e.addr});
        checkOutput("wr_data", mem_data, e.data);
      end
    end
    if (tx_valid && tx_ready) begin
      n_replies++;
      if (rq.size() == 0) begin
        checkOutput("extra_reply", {31'd0, tx_valid}, 32'd0);
      end else begin
        logic [7:0] r;
        r = rq.pop_front();
        checkOutput("reply_byte", {24'd0, tx_data}, {24'd0, r});
      end
    end
  end

  // Global time limit so a stuck DUT still ends the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] cnt);
    logic [31:0] word;
    word = 32'd0;
    payload_sum = 8'd0;
    applyStimulus(HEADER);
    checkOutput("hdr_core_reset", {31'd0, core_reset}, 32'd1);
    checkOutput("hdr_busy", {31'd0, busy}, 32'd1);
    applyStimulus(cnt);
    foreach (payload[i]) begin
      word[(i % 4) * 8 +: 8] = payload[i];
      payload_sum = payload_sum + payload[i];
      if (i % 4 == 3) begin
        wq.push_back('{addr: 5'(i / 4), data: word});
      end
      applyStimulus(payload[i]);
    end
  endtask

  task automatic waitReply(input string tag);
    int n;
    n = 0;
    while (!(tx_valid && tx_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(tx_valid && tx_ready)) begin
      checkOutput(tag, 32'd0, 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    int   n;
    int   r0;
    logic seen;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_core_reset", {31'd0, core_reset}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single-word frame with good checksum");
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    sendFrame(8'h01);
    rq.push_back(ACK_BYTE);
    applyStimulus(payload_sum);
    waitReply("t1_reply_timeout");
    checkOutput("t1_core_reset", {31'd0, core_reset}, 32'd0);
    checkOutput("t1_err", {31'd0, err}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd0);
    checkOutput("t1_writes_left", wq.size(), 32'd0);

    $display("[TB] full-depth frame with COUNT of zero");
    payload.delete();
    for (int k = 0; k < 128; k++) payload.push_back(8'(k));
    sendFrame(8'h00);
    rq.push_back(ACK_BYTE);
    applyStimulus(payload_sum);
    waitReply("t2_reply_timeout");
    checkOutput("t2_writes_left", wq.size(), 32'd0);
    checkOutput("t2_core_reset", {31'd0, core_reset}, 32'd0);

    $display("[TB] bad checksum then recovery frame");
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    sendFrame(8'h01);
    rq.push_back(NAK_BYTE);
    applyStimulus(8'h00);
    waitReply("t3_reply_timeout");
    checkOutput("t3_err", {31'd0, err}, 32'd1);
    checkOutput("t3_core_reset", {31'd0, core_reset}, 32'd1);
    checkOutput("t3_writes_left", wq.size(), 32'd0);
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    sendFrame(8'h01);
    rq.push_back(ACK_BYTE);
    applyStimulus(payload_sum);
    waitReply("t3b_reply_timeout");
    checkOutput("t3b_core_reset", {31'd0, core_reset}, 32'd0);
    checkOutput("t3b_err", {31'd0, err}, 32'd0);

    $display("[TB] oversized COUNT");
    payload.delete();
    rq.push_back(NAK_BYTE);
    sendFrame(8'h21);
    waitReply("t4_reply_timeout");
    checkOutput("t4_err", {31'd0, err}, 32'd1);
    checkOutput("t4_writes_left", wq.size(), 32'd0);

    $display("[TB] inter-byte timeout");
    payload = '{8'h01, 8'h02, 8'h03};
    rq.push_back(NAK_BYTE);
    sendFrame(8'h02);
    n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_timeout_cycles", n, 32'd101);
    @(negedge clk);
    checkOutput("t4_timeout_err", {31'd0, err}, 32'd1);
    checkOutput("t4_timeout_core_reset", {31'd0, core_reset}, 32'd1);
    checkOutput("t4_timeout_busy", {31'd0, busy}, 32'd0);

    $display("[TB] stray bytes in idle and held-off reply");
    applyStimulus(8'h00);
    checkOutput("t5_busy_00", {31'd0, busy}, 32'd0);
    applyStimulus(8'hFF);
    checkOutput("t5_busy_ff", {31'd0, busy}, 32'd0);
    applyStimulus(8'h5A);
    checkOutput("t5_busy_5a", {31'd0, busy}, 32'd0);
    checkOutput("t5_err_kept", {31'd0, err}, 32'd1);
    payload = '{8'h10, 8'h20, 8'h30, 8'h40};
    sendFrame(8'h01);
    tx_ready = 1'b0;
    rq.push_back(ACK_BYTE);
    applyStimulus(payload_sum);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    checkOutput("t5_valid_held", {31'd0, seen}, 32'd0);
    checkOutput("t5_busy_held", {31'd0, busy}, 32'd1);
    r0 = n_replies;
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_valid_up", {31'd0, tx_valid}, 32'd1);
    @(negedge clk);
    checkOutput("t5_valid_down", {31'd0, tx_valid}, 32'd0);
    checkOutput("t5_core_reset", {31'd0, core_reset}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t5_one_handshake", n_replies - r0, 32'd1);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(HEADER);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    reset = 1'b1;
    #1;
    checkOutput("t6_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("t6_mem_data", mem_data, 32'd0);
    checkOutput("t6_mem_addr", {27'd0, mem_addr}, 32'd0);
    checkOutput("t6_core_reset", {31'd0, core_reset}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_err", {31'd0, err}, 32'd0);
    checkOutput("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    sendFrame(8'h01);
    rq.push_back(ACK_BYTE);
    applyStimulus(payload_sum);
    waitReply("t6_reply_timeout");
    checkOutput("t6_after_core_reset", {31'd0, core_reset}, 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("end_writes_left", wq.size(), 32'd0);
    checkOutput("end_replies_left", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
